// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit ripple slice (pa) reused once per nibble, LSB nibble first.
// Optional macro SUB_MODE_EN adds a `sub` port that turns the operation into a - b.

module pa (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUB_MODE_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [CNT_W-1:0] nib_idx
);

    localparam int NIBBLES = WIDTH / 4;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [3:0]       a_nib, b_nib, pa_s;
    logic             pa_cout;

    // Select the active nibble of each captured operand.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    pa u_pa (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (pa_s),
        .cout (pa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
`ifdef SUB_MODE_EN
                    // Subtraction is a + ~b + 1; inverting at capture keeps RUN unchanged.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[4*i +: 4] = pa_s;
                    end
                end
                carry_d = pa_cout;
                if (cnt_q == LAST_NIB) begin
                    cout_d  = pa_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign nib_idx   = (state_q == RUN) ? cnt_q : '0;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl: a 16-bit and a 4-bit instance on a shared clock/reset.
// Define SUB_MODE_EN for both the RTL and this bench to exercise subtraction.

module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [15:0] a, b, sum;
    logic [3:0]  nib_idx;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, busy4;
    logic [3:0]  a4, b4, sum4;
    logic [3:0]  nib_idx4;

`ifdef SUB_MODE_EN
    logic        sub, sub4;
`endif

    int n_tests;
    int n_fail;

    nibble_serial_adder_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SUB_MODE_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .nib_idx   (nib_idx)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
`ifdef SUB_MODE_EN
        .sub       (sub4),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .busy      (busy4),
        .nib_idx   (nib_idx4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if ({in_ready, out_valid, busy, cout, nib_idx, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset16: rdy=%b vld=%b busy=%b cout=%b idx=%0d sum=%h, want rdy=1 vld=0 busy=0 cout=0 idx=0 sum=0000",
                     in_ready, out_valid, busy, cout, nib_idx, sum);
        end
        n_tests++;
        if ({in_ready4, out_valid4, busy4, cout4, sum4} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset4: rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 0", in_ready4, out_valid4, busy4, cout4, sum4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Accept one operand pair, check nib_idx and latency, check result, then retire it.
    task automatic run_add(input string name, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                           input logic sb, input logic [15:0] exp_sum, input logic exp_cout);
        a = av; b = bv; cin = ci; in_valid = 1'b1;
`ifdef SUB_MODE_EN
        sub = sb;
`endif
        if (sb) begin end
        tick();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || nib_idx !== 4'(k)) begin
                n_fail++;
                $display("FAIL %s run%0d: busy=%b rdy=%b vld=%b idx=%0d, want busy=1 rdy=0 vld=0 idx=%0d",
                         name, k, busy, in_ready, out_valid, nib_idx, k);
            end
            tick();
        end
        n_tests++;
        if (out_valid !== 1'b1 || sum !== exp_sum || cout !== exp_cout || nib_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL %s result: vld=%b sum=%h cout=%b idx=%0d, want vld=1 sum=%h cout=%b idx=0",
                     name, out_valid, sum, cout, nib_idx, exp_sum, exp_cout);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s retire: vld=%b rdy=%b busy=%b, want 0 1 0", name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_basic_add();
        run_add("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0);
        run_add("add_ffff_1_c0", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_add("add_ffff_1_c1", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1);
    endtask

    task automatic test_backpressure();
        a = 16'h00F0; b = 16'h0F0F; cin = 1'b1; in_valid = 1'b1;
`ifdef SUB_MODE_EN
        sub = 1'b0;
`endif
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        // 0x00F0 + 0x0F0F + 1 = 0x1000; now held in DONE while in_valid pulses with other operands.
        a = 16'h0003; b = 16'h0004; cin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = (k != 1);
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h1000 || cout !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h cout=%b busy=%b, want 1 0 1000 0 1",
                         k, out_valid, in_ready, sum, cout, busy);
            end
            tick();
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: rdy=%b vld=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || nib_idx !== 4'd0 || sum !== 16'h0000) begin
            n_fail++;
            $display("FAIL bp_accept: busy=%b idx=%0d sum=%h, want busy=1 idx=0 sum=0000", busy, nib_idx, sum);
        end
        repeat (4) tick();
        n_tests++;
        if (out_valid !== 1'b1 || sum !== 16'h0007 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_result: vld=%b sum=%h cout=%b, want 1 0007 0", out_valid, sum, cout);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int seen_valid;
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
`ifdef SUB_MODE_EN
        sub = 1'b0;
`endif
        tick();
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (nib_idx !== 4'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: idx=%0d busy=%b, want idx=1 busy=1", nib_idx, busy);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, busy, cout, nib_idx, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000}) begin
            n_fail++;
            $display("FAIL rst_async: rdy=%b vld=%b busy=%b cout=%b idx=%0d sum=%h, want 1 0 0 0 0 0000",
                     in_ready, out_valid, busy, cout, nib_idx, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) seen_valid++;
        end
        n_tests++;
        if (seen_valid != 0) begin
            n_fail++;
            $display("FAIL rst_discard: %0d cycles with vld/busy set after reset, want 0", seen_valid);
        end
        run_add("add_after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
    endtask

    task automatic test_width4();
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; in_valid4 = 1'b1;
`ifdef SUB_MODE_EN
        sub4 = 1'b0;
`endif
        tick();
        in_valid4 = 1'b0;
        n_tests++;
        if (busy4 !== 1'b1 || out_valid4 !== 1'b0 || nib_idx4 !== 4'd0 || in_ready4 !== 1'b0) begin
            n_fail++;
            $display("FAIL w4_run: busy=%b vld=%b idx=%0d rdy=%b, want 1 0 0 0", busy4, out_valid4, nib_idx4, in_ready4);
        end
        tick();
        n_tests++;
        if (out_valid4 !== 1'b1 || sum4 !== 4'h2 || cout4 !== 1'b1) begin
            n_fail++;
            $display("FAIL w4_result: vld=%b sum=%h cout=%b, want 1 2 1", out_valid4, sum4, cout4);
        end
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        n_tests++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL w4_retire: vld=%b rdy=%b, want 0 1", out_valid4, in_ready4);
        end
    endtask

    task automatic test_sub_mode();
`ifdef SUB_MODE_EN
        run_add("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run_add("sub_7_5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
        run_add("sub_cin_ignored", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef SUB_MODE_EN
        sub = 1'b0; sub4 = 1'b0;
`endif
        test_reset();
        test_basic_add();
        test_backpressure();
        test_reset_mid_run();
        test_width4();
        test_sub_mode();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
